// File: rtl/pkt_fifo_ctrl.sv
// Packet buffer with a read sequencer that releases whole packets, plus a CPU peek path.
// Optional macro PKT_FIFO_CPU_HOLD_EN builds the HOLD state and the CPU in-place word write.
//
// state | meaning
// IDLE  | waiting for a complete packet (pkt_cnt > 0)
// HOLD  | packet parked for CPU inspection/edit; leaves on a cpu_done rising edge
// SEND  | streaming words from head_addr whenever out_rdy is high
// WAIT  | single gap cycle after the eop word has been issued
module pkt_fifo_ctrl #(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH/8,
    parameter int ADDR_WIDTH        = 10,
    parameter int UDP_REG_SRC_WIDTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DATA_WIDTH-1:0]            in_data,
    input  logic [CTRL_WIDTH-1:0]            in_ctrl,
    input  logic                             in_wr,
    output logic                             in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    input  logic [ADDR_WIDTH-1:0]            cpu_in_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] cpu_in_data,
    input  logic                             cpu_in_wen,
    input  logic                             cpu_hold_en,
    input  logic                             cpu_done,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0] cpu_out_data,
    output logic [1:0]                       state,
    output logic [ADDR_WIDTH-1:0]            head_addr,
    output logic [ADDR_WIDTH-1:0]            tail_addr,
    output logic [ADDR_WIDTH:0]              pkt_cnt
);
    localparam int PW    = DATA_WIDTH + CTRL_WIDTH;
    localparam int MW    = PW + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, SEND = 2'd2, WAIT = 2'd3} state_t;

    state_t                state_q, state_d;
    logic [MW-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d, pcnt_q, pcnt_d;
    logic                  prev_zero_q, prev_zero_d;
    logic                  out_wr_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CTRL_WIDTH-1:0] out_ctrl_q;
    logic [PW-1:0]         cpu_out_q;

    logic                  wr_en, wr_eop, rd_en, rd_eop;
    logic [MW-1:0]         head_word;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic                  done_rise, cpu_wr, hold_req;
    logic [UDP_REG_SRC_WIDTH-1:0] unused_reg_src;

    assign unused_reg_src = '0;

    // Count never exceeds DEPTH, so its MSB alone means "full".
    assign in_rdy    = ~wcnt_q[ADDR_WIDTH];
    assign wr_en     = in_wr & in_rdy;
    assign wr_eop    = (in_ctrl != '0) & prev_zero_q;
    assign head_word = mem[head_q];
    assign rd_en     = (state_q == SEND) & out_rdy & (wcnt_q != '0);
    assign rd_eop    = head_word[MW-1];
    assign cpu_addr  = head_q + cpu_in_addr;

`ifdef PKT_FIFO_CPU_HOLD_EN
    logic done_q, wen_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
            wen_q  <= 1'b0;
        end else begin
            done_q <= cpu_done;
            wen_q  <= cpu_in_wen;
        end
    end

    assign done_rise = cpu_done & ~done_q;
    assign cpu_wr    = cpu_in_wen & ~wen_q & (state_q == HOLD);
    assign hold_req  = cpu_hold_en;
`else
    logic unused_cpu;

    assign unused_cpu = ^{cpu_in_data, cpu_in_wen, cpu_hold_en, cpu_done};
    assign done_rise  = 1'b0;
    assign cpu_wr     = 1'b0;
    assign hold_req   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[tail_q] <= {wr_eop, in_ctrl, in_data};
        end
`ifdef PKT_FIFO_CPU_HOLD_EN
        // HOLD only addresses complete packets, so this never collides with the tail write.
        if (cpu_wr) begin
            mem[cpu_addr] <= {mem[cpu_addr][MW-1], cpu_in_data};
        end
`endif
    end

    always_comb begin
        tail_d      = tail_q;
        head_d      = head_q;
        prev_zero_d = prev_zero_q;
        wcnt_d      = wcnt_q;
        pcnt_d      = pcnt_q;
        if (wr_en) begin
            tail_d      = tail_q + 1'b1;
            prev_zero_d = (in_ctrl == '0);
        end
        if (rd_en) begin
            head_d = head_q + 1'b1;
        end
        unique case ({wr_en, rd_en})
            2'b10:   wcnt_d = wcnt_q + 1'b1;
            2'b01:   wcnt_d = wcnt_q - 1'b1;
            default: wcnt_d = wcnt_q;
        endcase
        unique case ({wr_en & wr_eop, rd_en & rd_eop})
            2'b10:   pcnt_d = pcnt_q + 1'b1;
            2'b01:   pcnt_d = pcnt_q - 1'b1;
            default: pcnt_d = pcnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pcnt_q != '0) state_d = hold_req ? HOLD : SEND;
            HOLD: if (done_rise) state_d = SEND;
            SEND: if (rd_en && rd_eop) state_d = WAIT;
            WAIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            wcnt_q      <= '0;
            pcnt_q      <= '0;
            prev_zero_q <= 1'b0;
            out_wr_q    <= 1'b0;
            out_data_q  <= '0;
            out_ctrl_q  <= '0;
            cpu_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            wcnt_q      <= wcnt_d;
            pcnt_q      <= pcnt_d;
            prev_zero_q <= prev_zero_d;
            out_wr_q    <= rd_en;
            if (rd_en) begin
                {out_ctrl_q, out_data_q} <= head_word[PW-1:0];
            end
            cpu_out_q   <= mem[cpu_addr][PW-1:0];
        end
    end

    assign out_wr       = out_wr_q;
    assign out_data     = out_data_q;
    assign out_ctrl     = out_ctrl_q;
    assign cpu_out_data = cpu_out_q;
    assign state        = state_q;
    assign head_addr    = head_q;
    assign tail_addr    = tail_q;
    assign pkt_cnt      = pcnt_q;

endmodule

// File: tb/tb_pkt_fifo_ctrl.sv
// Scoreboard bench for pkt_fifo_ctrl: expected words queued at input, checked at output.
module tb_pkt_fifo_ctrl;
    localparam int DW = 64;
    localparam int CW = 8;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_wr = 1'b0;
    logic          in_rdy;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          out_wr;
    logic          out_rdy = 1'b1;
    logic [AW-1:0] cpu_in_addr = '0;
    logic [DW+CW-1:0] cpu_in_data = '0;
    logic          cpu_in_wen = 1'b0;
    logic          cpu_hold_en = 1'b0;
    logic          cpu_done = 1'b0;
    logic [DW+CW-1:0] cpu_out_data;
    logic [1:0]    state;
    logic [AW-1:0] head_addr, tail_addr;
    logic [AW:0]   pkt_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DW+CW-1:0] exp_q[$];

    pkt_fifo_ctrl #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .ADDR_WIDTH(AW), .UDP_REG_SRC_WIDTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .cpu_in_addr(cpu_in_addr), .cpu_in_data(cpu_in_data), .cpu_in_wen(cpu_in_wen),
        .cpu_hold_en(cpu_hold_en), .cpu_done(cpu_done), .cpu_out_data(cpu_out_data),
        .state(state), .head_addr(head_addr), .tail_addr(tail_addr), .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [CW-1:0] c, input logic [DW-1:0] d);
        in_ctrl = c;
        in_data = d;
        in_wr   = 1'b1;
        if (in_rdy) exp_q.push_back({c, d});
        tick();
        in_wr = 1'b0;
    endtask

    task automatic send_pkt(input int len);
        for (int i = 0; i < len; i++) begin
            logic [CW-1:0] c;
            c = (i == 0) ? 8'hFF : ((i == len - 1) ? 8'h01 : 8'h00);
            send_word(c, {$urandom, $urandom});
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || state != 2'd0 || out_wr) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_in_time", 128'(n < max_cyc), 128'(1));
    endtask

    always @(negedge clk) begin
        if (reset && out_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_word", 128'({out_ctrl, out_data}), 128'(0));
            end else begin
                logic [DW+CW-1:0] e;
                e = exp_q.pop_front();
                chk("out_word", 128'({out_ctrl, out_data}), 128'(e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk("rst_state", 128'(state), 128'(0));
        chk("rst_head", 128'(head_addr), 128'(0));
        chk("rst_tail", 128'(tail_addr), 128'(0));
        chk("rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("rst_out_wr", 128'(out_wr), 128'(0));
        chk("rst_out_data", 128'({out_ctrl, out_data}), 128'(0));
        chk("rst_cpu_out", 128'(cpu_out_data), 128'(0));
        reset = 1'b1;
        tick();
        chk("rst_in_rdy", 128'(in_rdy), 128'(1));

        // Basic 8-word packet, start-of-read latency
        send_pkt(8);
        chk("p8_pkt_cnt", 128'(pkt_cnt), 128'(1));
        chk("p8_idle", 128'(state), 128'(0));
        tick();
        chk("p8_send", 128'(state), 128'(2));
        chk("p8_no_wr_yet", 128'(out_wr), 128'(0));
        tick();
        chk("p8_first_wr", 128'(out_wr), 128'(1));
        wait_drain(100);
        chk("p8_pkt_cnt_done", 128'(pkt_cnt), 128'(0));

`ifdef PKT_FIFO_CPU_HOLD_EN
        // Hold with cpu_done already high, then edit word 3 and release
        cpu_hold_en = 1'b1;
        cpu_done    = 1'b1;
        cpu_in_addr = 10'd3;
        send_pkt(8);
        tick();
        chk("hold_enter", 128'(state), 128'(1));
        repeat (4) tick();
        chk("hold_done_level", 128'(state), 128'(1));
        chk("hold_peek", 128'(cpu_out_data), 128'(exp_q[3]));
        cpu_in_data = 72'h00_DEADBEEFCAFEF00D;
        cpu_in_wen  = 1'b1;
        tick();
        cpu_in_wen  = 1'b0;
        exp_q[3]    = 72'h00_DEADBEEFCAFEF00D;
        repeat (2) tick();
        chk("hold_peek_mod", 128'(cpu_out_data), 128'(72'h00_DEADBEEFCAFEF00D));
        cpu_done = 1'b0;
        tick();
        chk("hold_still", 128'(state), 128'(1));
        cpu_done = 1'b1;
        tick();
        chk("hold_release", 128'(state), 128'(2));
        cpu_hold_en = 1'b0;
        wait_drain(100);
        cpu_done = 1'b0;
`else
        // Hold controls have no effect in this build
        cpu_hold_en = 1'b1;
        cpu_in_addr = 10'd3;
        send_pkt(8);
        cpu_in_wen = 1'b1;
        tick();
        chk("nohold_send", 128'(state), 128'(2));
        cpu_in_wen  = 1'b0;
        cpu_hold_en = 1'b0;
        wait_drain(100);
`endif

        // 16-word packet with out_rdy toggling every cycle
        out_rdy = 1'b0;
        send_pkt(16);
        for (int i = 0; i < 200 && !(exp_q.size() == 0 && state == 2'd0 && !out_wr); i++) begin
            out_rdy = (i % 2 == 0);
            tick();
        end
        chk("toggle_left", 128'(exp_q.size()), 128'(0));
        chk("toggle_pkt_cnt", 128'(pkt_cnt), 128'(0));
        out_rdy = 1'b1;

        // Simultaneous eop write and eop read, then back-to-back packet spacing
        out_rdy = 1'b0;
        send_pkt(4);
        send_word(8'hFF, {$urandom, $urandom});
        send_word(8'h00, {$urandom, $urandom});
        send_word(8'h00, {$urandom, $urandom});
        chk("sim_pre_cnt", 128'(pkt_cnt), 128'(1));
        chk("sim_pre_state", 128'(state), 128'(2));
        out_rdy = 1'b1;
        repeat (3) tick();
        send_word(8'h01, {$urandom, $urandom});
        chk("sim_cnt_same", 128'(pkt_cnt), 128'(1));
        chk("b2b_wait", 128'(state), 128'(3));
        tick();
        chk("b2b_idle", 128'(state), 128'(0));
        tick();
        chk("b2b_send", 128'(state), 128'(2));
        wait_drain(100);
        chk("b2b_pkt_cnt", 128'(pkt_cnt), 128'(0));

        // Reset in the middle of SEND
        send_pkt(8);
        repeat (3) tick();
        chk("mid_out_wr_pre", 128'(out_wr), 128'(1));
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_wr", 128'(out_wr), 128'(0));
        chk("mid_rst_state", 128'(state), 128'(0));
        chk("mid_rst_pkt_cnt", 128'(pkt_cnt), 128'(0));
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_in_rdy", 128'(in_rdy), 128'(1));
        send_pkt(8);
        wait_drain(100);
        chk("post_rst_pkt_cnt", 128'(pkt_cnt), 128'(0));

        // Fill to full with the output blocked, then drain and confirm pointer wrap
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_rdy = 1'b0;
        tick();
        for (int p = 0; p < 64; p++) send_pkt(16);
        chk("full_in_rdy", 128'(in_rdy), 128'(0));
        chk("full_tail", 128'(tail_addr), 128'(0));
        chk("full_pkt_cnt", 128'(pkt_cnt), 128'(64));
        chk("full_out_wr", 128'(out_wr), 128'(0));
        send_word(8'h00, 64'h1234_5678_9ABC_DEF0);
        chk("full_extra_tail", 128'(tail_addr), 128'(0));
        chk("full_extra_q", 128'(exp_q.size()), 128'(1024));
        cpu_in_addr = 10'd5;
        tick();
        chk("full_peek", 128'(cpu_out_data), 128'(exp_q[5]));
        out_rdy = 1'b1;
        wait_drain(3000);
        chk("drain_head", 128'(head_addr), 128'(0));
        chk("drain_tail", 128'(tail_addr), 128'(0));
        chk("drain_pkt_cnt", 128'(pkt_cnt), 128'(0));
        chk("drain_in_rdy", 128'(in_rdy), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
